// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt pending controller.
// Holds the default sizing constants, the vector and index types,
// and the controller state encoding.
package irq_pkg;

  localparam int N_IRQ       = 4;
  localparam int IDW         = 2;
  localparam int TMO_DEFAULT = 15;

  typedef logic [N_IRQ-1:0] irq_vec_t;
  typedef logic [IDW-1:0]   irq_id_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } irq_state_e;

  // Mask with only bit 'id' set; this is the bit cleared when a service is acknowledged.
  function automatic irq_vec_t irq_onehot(input irq_id_t id);
    irq_vec_t v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage : irq_pkg

// File: rtl/irq_edge_det.sv
// Per-bit rising-edge detector with asynchronous active-high reset.
// The module exists only in builds that define IRQ_EDGE_DETECT_EN. Level-mode
// builds leave it out, so no edge detector is left behind as an unused top.
`ifdef IRQ_EDGE_DETECT_EN
module irq_edge_det #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] req_d_q;

  // Remember the previous sample of every line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_d_q <= '0;
    end else begin
      req_d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~req_d_q;

endmodule : irq_edge_det
`endif

// File: rtl/irq_pending_ctrl.sv
// Upstream stage of the 4-to-2 priority encoder.
// Raw requests collect in a sticky pending register. The masked vector goes out
// to the external encoder. The encoder result is latched and shown as irq/irq_id
// until it is acknowledged or the timeout ends the service.
// Optional feature: define IRQ_EDGE_DETECT_EN to pend on rising edges of req_in.
// In the default build, req_in is level sensitive.
//
// state | meaning
// IDLE  | nothing presented; pick the encoder result when enc_valid is high
// SERVE | irq/irq_id held; wait for ack or timeout
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter int N   = N_IRQ,
  parameter int IDW = $clog2(N),
  parameter int TMO = TMO_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_in,
  input  logic [N-1:0]   mask,
  output logic [N-1:0]   pend_o,
  input  logic [IDW-1:0] enc_y,
  input  logic           enc_valid,
  output logic           irq,
  output logic [IDW-1:0] irq_id,
  input  logic           ack,
  output logic           timeout
);

  // Wide enough to hold TMO. The FSM leaves SERVE when cnt reaches TMO-1, so cnt never wraps.
  localparam int CW = $clog2(TMO + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);
  localparam logic [N-1:0]  BIT0     = N'(1);

  irq_state_e     state_q, state_d;
  logic [N-1:0]   pend_q, pend_d;
  logic           irq_q, irq_d;
  logic [IDW-1:0] irq_id_q, irq_id_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           timeout_q, timeout_d;
  logic [N-1:0]   set;
  logic [N-1:0]   clr;

`ifdef IRQ_EDGE_DETECT_EN
  irq_edge_det #(
    .W (N)
  ) u_edge_det (
    .clk    (clk),
    .rst    (rst),
    .d_i    (req_in),
    .rise_o (set)
  );
`else
  assign set = req_in;
`endif

  // FSM next-state logic plus irq/irq_id/timeout updates and the ack clear mask.
  always_comb begin
    state_d   = state_q;
    irq_d     = irq_q;
    irq_id_d  = irq_id_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    clr       = '0;
    unique case (state_q)
      IDLE: begin
        if (enc_valid) begin
          irq_id_d = enc_y;
          irq_d    = 1'b1;
          cnt_d    = '0;
          state_d  = SERVE;
        end
      end
      SERVE: begin
        if (ack) begin
          clr     = BIT0 << irq_id_q;
          irq_d   = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // Give up on this request but leave it pending. It is offered again after one idle cycle.
          irq_d     = 1'b0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pending update. If set and clear hit the same bit in one cycle, set wins and the bit stays pending.
  always_comb begin
    pend_d = (pend_q & ~clr) | set;
  end

  // Registers for state, pending bits and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      irq_q     <= 1'b0;
      irq_id_q  <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      irq_q     <= irq_d;
      irq_id_q  <= irq_id_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign pend_o  = pend_q & mask;
  assign irq     = irq_q;
  assign irq_id  = irq_id_q;
  assign timeout = timeout_q;

endmodule : irq_pending_ctrl

// File: tb/tb_irq_pending_ctrl.sv
// Self-checking bench for irq_pending_ctrl.
// It contains a behavioural highest-index priority encoder and a transaction-level reference model.
module tb_irq_pending_ctrl;

  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req_in = '0;
  logic [3:0] mask = 4'hF;
  logic [3:0] pend_o;
  logic [1:0] enc_y;
  logic       enc_valid;
  logic       irq;
  logic [1:0] irq_id;
  logic       ack = 1'b0;
  logic       timeout;

  int n_checks = 0;
  int n_pass   = 0;

  irq_pending_ctrl #(
    .N   (4),
    .IDW (2),
    .TMO (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .mask      (mask),
    .pend_o    (pend_o),
    .enc_y     (enc_y),
    .enc_valid (enc_valid),
    .irq       (irq),
    .irq_id    (irq_id),
    .ack       (ack),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // External encoder: the highest set index wins.
  always_comb begin
    enc_y     = 2'd0;
    enc_valid = |pend_o;
    for (int i = 0; i < 4; i++) begin
      if (pend_o[i]) enc_y = 2'(i);
    end
  end

  // Reference model state.
  logic [3:0] m_pend;
  logic [3:0] m_prev_req;
  logic       m_busy;
  logic [1:0] m_id;
  int         m_age;
  logic       m_tmo;

  task automatic model_reset();
    m_pend = '0; m_prev_req = '0; m_busy = 1'b0; m_id = '0; m_age = 0; m_tmo = 1'b0;
  endtask

  // Advance the model by one clock edge, using the inputs applied before that edge.
  task automatic model_edge(input logic [3:0] r, input logic [3:0] msk, input logic a);
    logic [3:0] s;
    logic [3:0] c;
    logic [3:0] avail;
`ifdef IRQ_EDGE_DETECT_EN
    s = r & ~m_prev_req;
`else
    s = r;
`endif
    m_prev_req = r;
    c = (m_busy && a) ? (4'b0001 << m_id) : 4'b0000;
    m_tmo = 1'b0;
    avail = m_pend & msk;
    if (!m_busy) begin
      if (avail != 4'b0000) begin
        m_busy = 1'b1;
        m_age  = 1;
        for (int i = 0; i < 4; i++) if (avail[i]) m_id = 2'(i);
      end
    end else if (a) begin
      m_busy = 1'b0;
    end else if (m_age == TMO) begin
      m_busy = 1'b0;
      m_tmo  = 1'b1;
    end else begin
      m_age++;
    end
    m_pend = (m_pend & ~c) | s;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_in = '0; mask = 4'hF; ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_in = '0; mask = 4'hF; ack = 1'b0;
    #2;
    n_checks++;
    if ({pend_o, irq, irq_id, timeout} !== 8'b0) $display("FAIL reset_state got pend=%b irq=%b id=%b tmo=%b want all zero", pend_o, irq, irq_id, timeout);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_priority();
    do_reset();
    req_in = 4'b0101; tick();
    req_in = 4'b0000;
    n_checks++;
    if ({pend_o, irq} !== {4'b0101, 1'b0}) $display("FAIL prio_pend got pend=%b irq=%b want 0101/0", pend_o, irq);
    else n_pass++;
    tick();
    n_checks++;
    if ({irq, irq_id} !== {1'b1, 2'b10}) $display("FAIL prio_first got irq=%b id=%b want 1/10", irq, irq_id);
    else n_pass++;
    ack = 1'b1; tick(); ack = 1'b0;
    n_checks++;
    if ({pend_o, irq} !== {4'b0001, 1'b0}) $display("FAIL prio_ack1 got pend=%b irq=%b want 0001/0", pend_o, irq);
    else n_pass++;
    tick();
    n_checks++;
    if ({irq, irq_id} !== {1'b1, 2'b00}) $display("FAIL prio_second got irq=%b id=%b want 1/00", irq, irq_id);
    else n_pass++;
    ack = 1'b1; tick(); ack = 1'b0;
    n_checks++;
    if ({pend_o, irq} !== {4'b0000, 1'b0}) $display("FAIL prio_ack2 got pend=%b irq=%b want 0000/0", pend_o, irq);
    else n_pass++;
  endtask

  task automatic test_mask();
    logic seen_irq;
    do_reset();
    mask = 4'b0111; req_in = 4'b1000; tick(); req_in = 4'b0000;
    seen_irq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (irq) seen_irq = 1'b1;
      tick();
    end
    n_checks++;
    if ({pend_o, seen_irq} !== {4'b0000, 1'b0}) $display("FAIL mask_hold got pend=%b irq_seen=%b want 0000/0", pend_o, seen_irq);
    else n_pass++;
    mask = 4'b1111; #1;
    n_checks++;
    if (pend_o !== 4'b1000) $display("FAIL mask_open got pend=%b want 1000", pend_o);
    else n_pass++;
    tick();
    n_checks++;
    if ({irq, irq_id} !== {1'b1, 2'b11}) $display("FAIL mask_issue got irq=%b id=%b want 1/11", irq, irq_id);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int hi;
    do_reset();
    req_in = 4'b0010; tick(); req_in = 4'b0000; tick();
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (!irq) break;
      hi++;
      tick();
    end
    n_checks++;
    if (hi !== TMO) $display("FAIL tmo_len got %0d high cycles want %0d", hi, TMO);
    else n_pass++;
    n_checks++;
    if ({irq, timeout, pend_o} !== {1'b0, 1'b1, 4'b0010}) $display("FAIL tmo_pulse got irq=%b tmo=%b pend=%b want 0/1/0010", irq, timeout, pend_o);
    else n_pass++;
    tick();
    n_checks++;
    if ({irq, irq_id, timeout} !== {1'b1, 2'b01, 1'b0}) $display("FAIL tmo_reissue got irq=%b id=%b tmo=%b want 1/01/0", irq, irq_id, timeout);
    else n_pass++;
  endtask

  task automatic test_collision();
    do_reset();
    req_in = 4'b0010; tick(); req_in = 4'b0000; tick();
    n_checks++;
    if ({irq, irq_id} !== {1'b1, 2'b01}) $display("FAIL coll_issue got irq=%b id=%b want 1/01", irq, irq_id);
    else n_pass++;
    ack = 1'b1; req_in = 4'b0010; tick(); ack = 1'b0; req_in = 4'b0000;
    n_checks++;
    if ({pend_o, irq} !== {4'b0010, 1'b0}) $display("FAIL coll_pend got pend=%b irq=%b want 0010/0", pend_o, irq);
    else n_pass++;
    tick();
    n_checks++;
    if ({irq, irq_id} !== {1'b1, 2'b01}) $display("FAIL coll_reissue got irq=%b id=%b want 1/01", irq, irq_id);
    else n_pass++;
  endtask

  task automatic test_reset_mid_serve();
    do_reset();
    req_in = 4'b0100; tick(); req_in = 4'b0000; tick();
    n_checks++;
    if (irq !== 1'b1) $display("FAIL rst_pre got irq=%b want 1", irq);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({pend_o, irq, irq_id, timeout} !== 8'b0) $display("FAIL rst_async got pend=%b irq=%b id=%b tmo=%b want all zero", pend_o, irq, irq_id, timeout);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_edge_mode();
    int   issues;
    logic acked;
    logic prev_irq;
    do_reset();
    issues = 0; acked = 1'b0; prev_irq = 1'b0;
    req_in = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      tick();
      ack = 1'b0;
      if (irq && !prev_irq) issues++;
      prev_irq = irq;
      if (irq && !acked) begin
        ack = 1'b1;
        acked = 1'b1;
      end
    end
    req_in = 4'b0000; ack = 1'b0;
`ifdef IRQ_EDGE_DETECT_EN
    n_checks++;
    if ({issues, pend_o} !== {32'd1, 4'b0000}) $display("FAIL edge_once got issues=%0d pend=%b want 1/0000", issues, pend_o);
    else n_pass++;
`else
    n_checks++;
    if ((issues >= 2) !== 1'b1) $display("FAIL level_repend got issues=%0d want at least 2", issues);
    else n_pass++;
`endif
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic [3:0] msk;
    logic       a;
    int         errs;
    do_reset();
    errs = 0;
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      msk = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      a   = irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      req_in = r; mask = msk; ack = a;
      model_edge(r, msk, a);
      tick();
      n_checks++;
      if ({irq, irq_id, timeout, pend_o} !== {m_busy, m_id, m_tmo, m_pend & msk}) begin
        if (errs < 10) $display("FAIL rand_cycle%0d got irq=%b id=%b tmo=%b pend=%b want %b/%b/%b/%b",
                                i, irq, irq_id, timeout, pend_o, m_busy, m_id, m_tmo, m_pend & msk);
        errs++;
      end else n_pass++;
    end
    req_in = '0; ack = 1'b0; mask = 4'hF;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired want finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_priority();
    test_mask();
    test_timeout();
    test_collision();
    test_reset_mid_serve();
    test_edge_mode();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_irq_pending_ctrl
